// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters with registered one-hot grant, encoded index and a hold-cycle limit.
// Define ARB_FIXED_PRIO_EN to pin the search pointer at 0, which gives fixed lowest-index-wins priority.
module rr_arbiter_8 #(
    parameter int unsigned N        = 8,
    parameter int unsigned IDW      = 3,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_valid,
    output logic           forced_rel
);

    localparam int unsigned HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam bit HOLD_EN = (MAX_HOLD != 0);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   req_q;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [HCW-1:0] hold_cnt, hold_cnt_nxt;
    logic [N-1:0]   gnt_nxt;
    logic [IDW-1:0] gnt_id_nxt;
    logic           gnt_valid_nxt;
    logic           forced_rel_nxt;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic [IDW:0]   scan;
    logic           owner_req;
    logic           hold_hit;

    // Rotating search from ptr over the sampled request vector; first set bit wins.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        scan      = '0;
        for (int unsigned i = 0; i < N; i++) begin
            scan = {1'b0, ptr} + (IDW + 1)'(i);
            if (scan >= (IDW + 1)'(N)) begin
                scan = scan - (IDW + 1)'(N);
            end
            if (!win_found && req_q[scan[IDW-1:0]]) begin
                win_id    = scan[IDW-1:0];
                win_found = 1'b1;
            end
        end
    end

    assign owner_req = req_q[gnt_id];
    assign hold_hit  = HOLD_EN && (hold_cnt == HOLD_LAST);

    // Next-state and registered-output values.
    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        gnt_id_nxt     = gnt_id;
        gnt_valid_nxt  = gnt_valid;
        forced_rel_nxt = 1'b0;
        ptr_nxt        = ptr;
        hold_cnt_nxt   = hold_cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt     = GRANT;
                    gnt_nxt       = N'(1) << win_id;
                    gnt_id_nxt    = win_id;
                    gnt_valid_nxt = 1'b1;
                    hold_cnt_nxt  = '0;
                end
            end
            GRANT: begin
                if (!owner_req || hold_hit) begin
                    // A simultaneous drop on the limit edge counts as voluntary.
                    state_nxt      = IDLE;
                    gnt_nxt        = '0;
                    gnt_id_nxt     = '0;
                    gnt_valid_nxt  = 1'b0;
                    forced_rel_nxt = owner_req;
                    hold_cnt_nxt   = '0;
`ifdef ARB_FIXED_PRIO_EN
                    ptr_nxt        = '0;
`else
                    ptr_nxt        = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);
`endif
                end else if (HOLD_EN) begin
                    hold_cnt_nxt = hold_cnt + HCW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request sampling, state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= '0;
            ptr        <= '0;
            hold_cnt   <= '0;
            gnt        <= '0;
            gnt_id     <= '0;
            gnt_valid  <= 1'b0;
            forced_rel <= 1'b0;
        end else begin
            state      <= state_nxt;
            req_q      <= req;
            ptr        <= ptr_nxt;
            hold_cnt   <= hold_cnt_nxt;
            gnt        <= gnt_nxt;
            gnt_id     <= gnt_id_nxt;
            gnt_valid  <= gnt_valid_nxt;
            forced_rel <= forced_rel_nxt;
        end
    end

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_gnt_valid  : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));
    a_gnt_id     : assert property (@(posedge clk) disable iff (!rst_n)
                                    gnt == (gnt_valid ? (N'(1) << gnt_id) : '0));

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Sequential 8-requester arbiter that shares one downstream resource, built around the team's 8-to-3 priority encoding.
- Round-robin by default. Issues one registered one-hot grant plus its 3-bit encoded index.
- Bounds ownership with a hold-cycle limit so one requester cannot starve the others.
- Sits in front of any shared datapath: bus port, memory port or encoder output mux.

Parameters:
- N, 8, number of requesters; the design is verified only at 8.
- IDW, 3, grant index width; must equal clog2(N).
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership; 0 = unlimited.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  N  request vector; bit i high = requester i wants the resource. Requester holds it high while it uses the resource.
- gnt  out  N  one-hot grant; all zero when no owner.
- gnt_id  out  IDW  binary index of the owner; 0 when gnt_valid=0.
- gnt_valid  out  1  high while any grant is active.
- forced_rel  out  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, forced_rel=0.
  - ptr=0, hold_cnt=0.
- All outputs are registered; there are no combinational paths from req to any output.
- Priority search: scan the indices ptr, ptr+1, ..., ptr+N-1 mod N; the first set bit of req wins. After reset, bit 0 has highest priority.
- State IDLE:
  - If req==0: stay in IDLE.
  - Else at the next edge: state=GRANT, gnt[w]=1, gnt_id=w, gnt_valid=1, hold_cnt=0, where w is the winner.
  - Latency: req seen high at edge k gives gnt high after edge k+1.
- State GRANT, with owner o. At each edge:
  - Voluntary release, when req[o]==0: state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, ptr=(o+1) mod N.
  - Forced release, when MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and req[o]==1: same as voluntary release, and additionally forced_rel=1 for exactly one cycle.
  - Otherwise: hold_cnt++ and the grant is unchanged.
  - Changes to non-owner req bits during GRANT are ignored.
- Exactly one IDLE cycle separates consecutive grants. Throughput is at most one ownership per (hold+1) cycles.
- Grant duration:
  - The owner holds gnt for at least 1 cycle.
  - If it holds req throughout, it holds gnt for at most MAX_HOLD cycles.
- Wrap-around: when o=7, ptr becomes 0. ptr arithmetic is mod N in IDW bits.
- A requester that was forcibly released and keeps requesting re-competes with ptr=o+1:
  - Any other active requester wins first.
  - If it is the sole requester, it is re-granted after one IDLE cycle.
- Simultaneous drop of req[o] on the forced-release edge: treated as voluntary (forced_rel=0).
- hold_cnt width is clog2(MAX_HOLD+1). When MAX_HOLD=0 the counter is unused and only voluntary release applies.
- Reset mid-grant: grant drops asynchronously and ptr returns to 0.
- Invariants, checked by assertion:
  - gnt is one-hot or zero.
  - gnt_valid == |gnt.
  - gnt_id == encode(gnt).

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined:
  - ptr is held at 0 permanently; lowest index always wins, giving pure priority-encoder behaviour.
  - The hold limit and forced_rel still operate.
  - A forced-released owner re-wins if no lower-index requester is present.
- Undefined: round-robin as described above.

Test Plan:
1. Reset, then req=8'b0000_0001 held -> gnt=8'h01, gnt_id=0, gnt_valid=1 two edges after req. Under continuous req at MAX_HOLD=16: 16 grant cycles, forced_rel pulse, 1 IDLE cycle, then re-grant to 0.
2. req=8'hFF held, round-robin, 1-cycle grants via owner dropping and re-raising req -> gnt_id sequence 0,1,2,...,7,0, each grant separated by one IDLE cycle.
3. In ptr=5 state, req=8'b0010_0100 -> bit 5 wins first (gnt_id=5). After its release, bit 2 wins (gnt_id=2).
4. Owner 3 granted, req[3] dropped on the same edge that hold_cnt reaches 15 -> gnt=0 next cycle, forced_rel stays 0.
5. rst_n pulsed low mid-grant (gnt_id=6) -> gnt=0 and gnt_valid=0 immediately, without a clock edge. After release with req=8'h41, gnt_id=0 wins.
6. With ARB_FIXED_PRIO_EN defined, req=8'h81 held -> gnt_id=0 repeatedly (16 cycles, IDLE, re-grant); gnt_id=7 is never granted.
